// File: rtl/dmac_pkg.sv
// Shared DMAC definitions: arbiter state encoding and default bus widths.
package dmac_pkg;

  localparam int DMAC_DW = 32;
  localparam int DMAC_AW = 8;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/bus_arb_mux_if.sv
// Shared-bus bundle between the DMA channel masters and the bus arbiter/mux.
interface bus_arb_mux_if #(
  parameter int N  = 4,
  parameter int DW = dmac_pkg::DMAC_DW,
  parameter int AW = dmac_pkg::DMAC_AW
);
  // Handshake: master i holds m_req[i] high for as long as it wants the bus;
  // it owns the bus while m_grant[i] is high and releases by dropping m_req[i].
  // s_valid qualifies s_wr/s_addr/s_dout; they are zero whenever s_valid is low.
  logic [N-1:0]    m_req;
  logic [N-1:0]    m_wr;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_dout;
  logic [N-1:0]    m_grant;
  logic            s_valid;
  logic            s_wr;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_dout;

  modport master (
    output m_req, m_wr, m_addr, m_dout,
    input  m_grant, s_valid, s_wr, s_addr, s_dout
  );

  modport slave (
    input  m_req, m_wr, m_addr, m_dout,
    output m_grant, s_valid, s_wr, s_addr, s_dout
  );
endinterface

// File: rtl/mux_onehot_nw.sv
// N-way AND-OR multiplexer with a one-hot select; all-zero select yields zero.
module mux_onehot_nw #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic [N-1:0]   sel,
  input  logic [N*W-1:0] din,
  output logic [W-1:0]   dout
);

  always_comb begin
    dout = '0;
    for (int i = 0; i < N; i++) begin
      dout = dout | (din[i*W +: W] & {W{sel[i]}});
    end
  end

endmodule

// File: rtl/bus_arb_mux.sv
// Round-robin N-master bus arbiter with bus lock and a registered one-hot data mux.
module bus_arb_mux
  import dmac_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = DMAC_DW,
  parameter int AW = DMAC_AW
) (
  input  logic         clk,
  input  logic         reset,
  bus_arb_mux_if.slave bus,
  output arb_state_e   dbg_state
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  arb_state_e    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] win;
  logic          found;

  logic              s_valid_q;
  logic              s_wr_q;
  logic [AW-1:0]     s_addr_q;
  logic [DW-1:0]     s_dout_q;
  logic [N*(AW+1)-1:0] wa_in;
  logic [AW:0]       wa_sel;
  logic [DW-1:0]     d_sel;

  // First requester at or above rr_q, wrapping past N-1 back to 0.
  always_comb begin
    logic [IW-1:0] idx;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(rr_q) + k) % N);
      if (!found && bus.m_req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    case (state_q)
      ARB_IDLE: begin
        if (found) begin
          grant_d      = '0;
          grant_d[win] = 1'b1;
          owner_d      = win;
          state_d      = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        // Release always passes through IDLE, so no same-edge handover.
        if (!bus.m_req[owner_q]) begin
          grant_d = '0;
          state_d = ARB_IDLE;
          rr_d    = (int'(owner_q) == N - 1) ? '0 : owner_q + IW'(1);
        end
      end
      default: begin
        grant_d = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign wa_in[i*(AW+1) +: AW+1] = {bus.m_wr[i], bus.m_addr[i*AW +: AW]};
  end

  mux_onehot_nw #(.N(N), .W(AW + 1)) u_mux_wa (
    .sel  (grant_q),
    .din  (wa_in),
    .dout (wa_sel)
  );

  mux_onehot_nw #(.N(N), .W(DW)) u_mux_d (
    .sel  (grant_q),
    .din  (bus.m_dout),
    .dout (d_sel)
  );

  // Data stage follows the grant register by one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_valid_q <= 1'b0;
      s_wr_q    <= 1'b0;
      s_addr_q  <= '0;
      s_dout_q  <= '0;
    end else begin
      s_valid_q          <= |grant_q;
      {s_wr_q, s_addr_q} <= wa_sel;
      s_dout_q           <= d_sel;
    end
  end

  assign bus.m_grant = grant_q;
  assign bus.s_valid = s_valid_q;
  assign bus.s_wr    = s_wr_q;
  assign bus.s_addr  = s_addr_q;
  assign bus.s_dout  = s_dout_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_bus_arb_mux.sv
// Self-checking bench for bus_arb_mux: directed scenarios plus randomized traffic
// against a transaction-level ownership model.
module tb_bus_arb_mux;
  import dmac_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int BW = N + 2 + AW + DW;

  logic clk;
  logic reset;
  arb_state_e dbg_state;

  bus_arb_mux_if #(.N(N), .DW(DW), .AW(AW)) bus ();

  bus_arb_mux #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stimulus state
  logic [N-1:0]  req_v;
  logic [N-1:0]  wr_v;
  logic [AW-1:0] addr_a [N];
  logic [DW-1:0] dout_a [N];

  // reference model: who owns the bus and where the next search starts
  int            mdl_owner;
  int            mdl_ptr;
  logic [N-1:0]  exp_grant;
  logic          exp_valid;
  logic          exp_wr;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_dout;
  logic [AW+DW:0] exp_q [$];

  int checks;
  int errors;

  function automatic logic [BW-1:0] got_bundle();
    return {bus.m_grant, bus.s_valid, bus.s_wr, bus.s_addr, bus.s_dout};
  endfunction

  function automatic logic [BW-1:0] exp_bundle();
    return {exp_grant, exp_valid, exp_wr, exp_addr, exp_dout};
  endfunction

  task automatic drive();
    bus.m_req = req_v;
    bus.m_wr  = wr_v;
    for (int i = 0; i < N; i++) begin
      bus.m_addr[i*AW +: AW] = addr_a[i];
      bus.m_dout[i*DW +: DW] = dout_a[i];
    end
  endtask

  // Apply current inputs, advance the model by one clock, then sample #1 after the edge.
  task automatic tick();
    drive();
    if (reset) begin
      mdl_owner = -1;
      mdl_ptr   = 0;
      exp_valid = 1'b0;
      exp_wr    = 1'b0;
      exp_addr  = '0;
      exp_dout  = '0;
    end else begin
      if (mdl_owner >= 0) begin
        exp_valid = 1'b1;
        exp_wr    = wr_v[mdl_owner];
        exp_addr  = addr_a[mdl_owner];
        exp_dout  = dout_a[mdl_owner];
        exp_q.push_back({exp_wr, exp_addr, exp_dout});
      end else begin
        exp_valid = 1'b0;
        exp_wr    = 1'b0;
        exp_addr  = '0;
        exp_dout  = '0;
      end
      if (mdl_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          if (mdl_owner < 0 && req_v[(mdl_ptr + k) % N]) mdl_owner = (mdl_ptr + k) % N;
        end
      end else if (!req_v[mdl_owner]) begin
        mdl_ptr   = (mdl_owner + 1) % N;
        mdl_owner = -1;
      end
    end
    exp_grant = (mdl_owner >= 0) ? (N'(1) << mdl_owner) : '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_v = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({bus.m_grant, bus.s_valid, bus.s_addr, bus.s_dout} !== '0) begin
        errors++;
        $display("FAIL reset cyc%0d: grant=%b valid=%b addr=%h dout=%h, required all zero",
                 c, bus.m_grant, bus.s_valid, bus.s_addr, bus.s_dout);
      end
      checks++;
      if (dbg_state !== ARB_IDLE) begin
        errors++;
        $display("FAIL reset_state cyc%0d: got %0d want IDLE", c, dbg_state);
      end
    end
    reset = 1'b0;
    req_v = '0;
    tick();
  endtask

  task automatic test_single();
    addr_a[2] = 8'h3C;
    dout_a[2] = 32'hDEADBEEF;
    wr_v[2]   = 1'b1;
    req_v     = 4'b0100;
    tick();
    checks++;
    if (bus.m_grant !== 4'b0100 || bus.s_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_grant: grant=%b valid=%b, required 0100/0", bus.m_grant, bus.s_valid);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({bus.m_grant, bus.s_valid, bus.s_wr, bus.s_addr, bus.s_dout} !==
          {4'b0100, 1'b1, 1'b1, 8'h3C, 32'hDEADBEEF}) begin
        errors++;
        $display("FAIL single_data cyc%0d: got %h, required %h", c, got_bundle(),
                 {4'b0100, 1'b1, 1'b1, 8'h3C, 32'hDEADBEEF});
      end
    end
    req_v = '0;
    tick();
    checks++;
    if (bus.m_grant !== 4'b0000 || bus.s_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_release: grant=%b valid=%b, required 0000/1", bus.m_grant, bus.s_valid);
    end
    tick();
    checks++;
    if ({bus.s_valid, bus.s_wr, bus.s_addr, bus.s_dout} !== '0) begin
      errors++;
      $display("FAIL single_idle: valid=%b wr=%b addr=%h dout=%h, required zero",
               bus.s_valid, bus.s_wr, bus.s_addr, bus.s_dout);
    end
  endtask

  task automatic test_rotation();
    int order [5];
    logic [N-1:0] want;
    order = '{0, 1, 2, 3, 0};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_v = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      want = N'(1) << order[i];
      tick();
      checks++;
      if (bus.m_grant !== want) begin
        errors++;
        $display("FAIL rotation_grant%0d: got %b, required %b", i, bus.m_grant, want);
      end
      tick();
      checks++;
      if (got_bundle() !== exp_bundle()) begin
        errors++;
        $display("FAIL rotation_hold%0d: got %h, required %h", i, got_bundle(), exp_bundle());
      end
      req_v[order[i]] = 1'b0;
      tick();
      checks++;
      if (bus.m_grant !== '0) begin
        errors++;
        $display("FAIL rotation_idle%0d: got %b, required 0000", i, bus.m_grant);
      end
      req_v = 4'b1111;
    end
    req_v = '0;
    tick();
    tick();
  endtask

  task automatic test_wrap();
    req_v = 4'b1000;
    tick();
    checks++;
    if (bus.m_grant !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_grant3: got %b, required 1000", bus.m_grant);
    end
    req_v = '0;
    tick();
    req_v = 4'b1010;
    tick();
    checks++;
    if (bus.m_grant !== 4'b0010) begin
      errors++;
      $display("FAIL wrap_ptr0: got %b, required 0010", bus.m_grant);
    end
  endtask

  task automatic test_reset_mid();
    req_v = 4'b0010;
    tick();
    checks++;
    if (bus.m_grant !== 4'b0010 || bus.s_valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre: grant=%b valid=%b, required 0010/1", bus.m_grant, bus.s_valid);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (bus.m_grant !== 4'b0000 || bus.s_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_drop: grant=%b valid=%b, required 0000/0", bus.m_grant, bus.s_valid);
    end
    reset = 1'b0;
    req_v = 4'b1010;
    tick();
    checks++;
    if (bus.m_grant !== 4'b0010) begin
      errors++;
      $display("FAIL midreset_regrant: got %b, required 0010", bus.m_grant);
    end
    req_v = '0;
    tick();
    tick();
  endtask

  task automatic test_isolation();
    addr_a[0] = 8'h11;
    dout_a[0] = 32'h0000A5A5;
    wr_v[0]   = 1'b1;
    req_v     = 4'b0001;
    tick();
    for (int c = 0; c < 8; c++) begin
      dout_a[1] = ~dout_a[1];
      addr_a[3] = ~addr_a[3];
      wr_v[3:1] = ~wr_v[3:1];
      tick();
      checks++;
      if ({bus.m_grant, bus.s_valid, bus.s_wr, bus.s_addr, bus.s_dout} !==
          {4'b0001, 1'b1, 1'b1, 8'h11, 32'h0000A5A5}) begin
        errors++;
        $display("FAIL isolation cyc%0d: got %h, required %h", c, got_bundle(),
                 {4'b0001, 1'b1, 1'b1, 8'h11, 32'h0000A5A5});
      end
    end
    req_v = '0;
    tick();
    tick();
  endtask

  task automatic test_random();
    logic [AW+DW:0] e;
    exp_q.delete();
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < N; i++) begin
        req_v[i]  = ($urandom_range(0, 3) != 0);
        wr_v[i]   = 1'($urandom);
        addr_a[i] = AW'($urandom);
        dout_a[i] = $urandom;
      end
      tick();
      checks++;
      if (got_bundle() !== exp_bundle()) begin
        errors++;
        $display("FAIL random cyc%0d: got %h, required %h", c, got_bundle(), exp_bundle());
      end
      checks++;
      if (!$onehot0(bus.m_grant)) begin
        errors++;
        $display("FAIL onehot cyc%0d: grant=%b", c, bus.m_grant);
      end
      checks++;
      if (dbg_state !== ((mdl_owner >= 0) ? ARB_BUSY : ARB_IDLE)) begin
        errors++;
        $display("FAIL random_state cyc%0d: got %0d, owner model %0d", c, dbg_state, mdl_owner);
      end
      if (bus.s_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard cyc%0d: unexpected transfer %h", c, bus.s_dout);
        end else begin
          e = exp_q.pop_front();
          if ({bus.s_wr, bus.s_addr, bus.s_dout} !== e) begin
            errors++;
            $display("FAIL scoreboard cyc%0d: got %h, required %h", c,
                     {bus.s_wr, bus.s_addr, bus.s_dout}, e);
          end
        end
      end else if (exp_q.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard cyc%0d: missing transfer %h", c, exp_q[0]);
        exp_q.delete();
      end
    end
    reset = 1'b0;
    req_v = '0;
    tick();
    tick();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    mdl_owner = -1;
    mdl_ptr   = 0;
    reset     = 1'b1;
    req_v     = '0;
    wr_v      = '0;
    for (int i = 0; i < N; i++) begin
      addr_a[i] = AW'($urandom);
      dout_a[i] = $urandom;
    end
    drive();
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_reset_mid();
    test_isolation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
